// File: rtl/path_stack_replay.sv
// path_stack_replay
//   Path stack for a maze solver: the solver pushes each direction step it
//   takes and pops when it backtracks.  On a fresh run request the stored
//   path is replayed oldest-first, one move pulse every two cycles, and a
//   one-cycle replayDone pulse marks the end of the replay.
//
// Parameters
//   DEPTH  number of stored direction entries (power of two, 2..256)
//   DW     direction code width (00 up, 01 right, 10 down, 11 left)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   push        store dirIn on top of the stack
//   pop         discard the top entry
//   dirIn       direction to push
//   run         replay request (needs a low cycle in IDLE to re-arm)
//   empStck     stack empty
//   full        stack holds DEPTH entries
//   busy        replay in progress; push/pop ignored while high
//   move        one-cycle pulse, dirOut valid in the same cycle
//   dirOut      replayed direction, holds its last value between moves
//   replayDone  one-cycle pulse at replay end
//   err         sticky overflow/underflow flag
//
// Build option
//   PATH_STACK_ERR_EN  when defined, err sets on push-when-full (push only)
//                      or pop-when-empty (pop only) and holds until reset;
//                      when undefined, err is tied low.

module path_stack_replay #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] dirIn,
  input  logic          run,
  output logic          empStck,
  output logic          full,
  output logic          busy,
  output logic          move,
  output logic [DW-1:0] dirOut,
  output logic          replayDone,
  output logic          err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] A_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;

  state_t        state_q;
  logic [AW:0]   sp_q, sp_d;
  logic [AW:0]   rd_ptr_q, rd_nxt;
  logic          armed_q;
  logic          move_q, done_q, busy_q;
  logic [DW-1:0] dir_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          stack_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign empStck    = (sp_q == '0);
  assign full       = (sp_q == SP_FULL);
  assign busy       = busy_q;
  assign move       = move_q;
  assign dirOut     = dir_q;
  assign replayDone = done_q;

  // The stack is only touched while the replay engine is idle.
  assign stack_en = (state_q == IDLE);
  assign rd_nxt   = rd_ptr_q + SP_ONE;

  always_comb begin
    sp_d    = sp_q;
    wr_en   = 1'b0;
    wr_addr = sp_q[AW-1:0];
    if (stack_en) begin
      if (push && pop) begin
        wr_en = 1'b1;
        if (empStck) begin
          sp_d = sp_q + SP_ONE;
        end else begin
          // Replace the top entry in place; depth is unchanged.
          wr_addr = sp_q[AW-1:0] - A_ONE;
        end
      end else if (push) begin
        if (!full) begin
          wr_en = 1'b1;
          sp_d  = sp_q + SP_ONE;
        end
      end else if (pop) begin
        if (!empStck) begin
          sp_d = sp_q - SP_ONE;
        end
      end
    end
  end

  // Storage has no reset: contents survive rst, only sp is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= dirIn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Replay FSM; move/dirOut/replayDone/busy are registered and loaded on
  // the transition into the state that presents them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      armed_q  <= 1'b0;
      move_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dir_q    <= '0;
    end else begin
      move_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!run) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q  <= 1'b0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b1;
            if (!empStck) begin
              state_q <= EMIT;
              move_q  <= 1'b1;
              dir_q   <= mem_q[0];
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        EMIT: begin
          state_q <= GAP;
        end
        GAP: begin
          rd_ptr_q <= rd_nxt;
          if (rd_nxt == sp_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= EMIT;
            move_q  <= 1'b1;
            dir_q   <= mem_q[rd_nxt[AW-1:0]];
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PATH_STACK_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (stack_en && ((push && !pop && full) || (pop && !push && empStck))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
